// File: rtl/global_reset_monitor.sv
// rtl/global_reset_monitor.sv - reset-request / battery-fail pin monitor with Avalon-MM register slave
module global_reset_monitor #(
    parameter int DEBOUNCE = 1000
) (
    input  logic       csi_clockreset_clk,
    input  logic       csi_clockreset_reset,
    input  logic [1:0] avs_monitor_address,
    input  logic [7:0] avs_monitor_writedata,
    output logic [7:0] avs_monitor_readdata,
    input  logic       avs_monitor_write_n,
    input  logic       avs_monitor_read_n,
    output logic       avs_monitor_waitrequest_n,
    output logic       ins_irq_irq,
    input  logic       RESET_IN,
    input  logic       BATFL_IN
);

    localparam logic [15:0] DEB_MAX = 16'(DEBOUNCE - 1);

    logic        rst_s1, rst_s2, bat_s1, bat_s2;
    logic        deb_rst, deb_bat;
    logic [15:0] cnt_rst, cnt_bat;
    logic [3:0]  event_q, mask_q, ev_set, ev_clr;
    logic [7:0]  batfl_cnt;
    logic        rst_upd, bat_upd, wr_event, wr_mask, wr_count;

    wire unused_ok = &{1'b0, avs_monitor_read_n, avs_monitor_writedata[7:4]};

    always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
            rst_s1 <= 1'b0;
            rst_s2 <= 1'b0;
            bat_s1 <= 1'b1;
            bat_s2 <= 1'b1;
        end else begin
            rst_s1 <= RESET_IN;
            rst_s2 <= rst_s1;
            bat_s1 <= BATFL_IN;
            bat_s2 <= bat_s1;
        end
    end

    assign rst_upd = (rst_s2 != deb_rst) && (cnt_rst == DEB_MAX);
    assign bat_upd = (bat_s2 != deb_bat) && (cnt_bat == DEB_MAX);

    always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
            deb_rst <= 1'b0;
            cnt_rst <= '0;
        end else if (rst_s2 == deb_rst) begin
            cnt_rst <= '0;
        end else if (rst_upd) begin
            deb_rst <= rst_s2;
            cnt_rst <= '0;
        end else begin
            cnt_rst <= cnt_rst + 16'd1;
        end
    end

    always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
            deb_bat <= 1'b1;
            cnt_bat <= '0;
        end else if (bat_s2 == deb_bat) begin
            cnt_bat <= '0;
        end else if (bat_upd) begin
            deb_bat <= bat_s2;
            cnt_bat <= '0;
        end else begin
            cnt_bat <= cnt_bat + 16'd1;
        end
    end

    assign ev_set = {bat_upd & bat_s2, bat_upd & ~bat_s2, rst_upd & ~rst_s2, rst_upd & rst_s2};

    assign wr_event = !avs_monitor_write_n && (avs_monitor_address == 2'd1);
    assign wr_mask  = !avs_monitor_write_n && (avs_monitor_address == 2'd2);
    assign wr_count = !avs_monitor_write_n && (avs_monitor_address == 2'd3);
    assign ev_clr   = wr_event ? avs_monitor_writedata[3:0] : 4'd0;

    // Sets are OR-ed in after the clear so a coincident event is never lost.
    always_ff @(posedge csi_clockreset_clk or posedge csi_clockreset_reset) begin
        if (csi_clockreset_reset) begin
            event_q     <= '0;
            mask_q      <= '0;
            batfl_cnt   <= '0;
            ins_irq_irq <= 1'b0;
        end else begin
            event_q     <= (event_q & ~ev_clr) | ev_set;
            ins_irq_irq <= |(event_q & mask_q);
            if (wr_mask)
                mask_q <= avs_monitor_writedata[3:0];
            if (wr_count)
                batfl_cnt <= {7'd0, ev_set[2]};
            else if (ev_set[2] && batfl_cnt != 8'hFF)
                batfl_cnt <= batfl_cnt + 8'd1;
        end
    end

    always_comb begin
        avs_monitor_readdata = 8'h00;
        case (avs_monitor_address)
            2'd0:    avs_monitor_readdata = {6'd0, deb_bat, deb_rst};
            2'd1:    avs_monitor_readdata = {4'd0, event_q};
            2'd2:    avs_monitor_readdata = {4'd0, mask_q};
            default: avs_monitor_readdata = batfl_cnt;
        endcase
    end

    assign avs_monitor_waitrequest_n = 1'b1;

endmodule

// File: tb/tb_global_reset_monitor.sv
// tb/tb_global_reset_monitor.sv - scoreboard bench for global_reset_monitor
module tb_global_reset_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] address = 2'd0;
    logic [7:0] writedata = 8'd0;
    logic [7:0] readdata;
    logic       write_n = 1'b1;
    logic       read_n = 1'b1;
    logic       waitrequest_n;
    logic       irq;
    logic       reset_in = 1'b1;
    logic       batfl_in = 1'b1;

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       irq;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    global_reset_monitor #(.DEBOUNCE(4)) dut (
        .csi_clockreset_clk        (clk),
        .csi_clockreset_reset      (rst),
        .avs_monitor_address       (address),
        .avs_monitor_writedata     (writedata),
        .avs_monitor_readdata      (readdata),
        .avs_monitor_write_n       (write_n),
        .avs_monitor_read_n        (read_n),
        .avs_monitor_waitrequest_n (waitrequest_n),
        .ins_irq_irq               (irq),
        .RESET_IN                  (reset_in),
        .BATFL_IN                  (batfl_in)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    always @(negedge clk) begin
        if (!read_n) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_read got data=%02h with no expectation queued", readdata);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (readdata !== e.data || irq !== e.irq || waitrequest_n !== 1'b1) begin
                    errors++;
                    $display("FAIL %s got data=%02h irq=%0b waitreq_n=%0b expected data=%02h irq=%0b waitreq_n=1",
                             e.name, readdata, irq, waitrequest_n, e.data, e.irq);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a, input logic [7:0] d, input logic i, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        address = a;
        read_n  = 1'b0;
        e.name = name;
        e.data = d;
        e.irq  = i;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        read_n = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        @(posedge clk);
        #1;
        address   = a;
        writedata = d;
        write_n   = 1'b0;
        @(posedge clk);
        #1;
        write_n = 1'b1;
    endtask

    initial begin
        // reset with RESET_IN already high
        step(2);
        rd(2'd0, 8'h02, 1'b0, "rst_status");
        rd(2'd1, 8'h00, 1'b0, "rst_event");
        rd(2'd3, 8'h00, 1'b0, "rst_count");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= 5; i++) rd(2'd0, 8'h02, 1'b0, "post_rst_pre_deb");
        rd(2'd0, 8'h03, 1'b0, "post_rst_deb_rise");
        rd(2'd1, 8'h01, 1'b0, "post_rst_ev0");
        wr(2'd1, 8'h01);
        rd(2'd1, 8'h00, 1'b0, "ev0_cleared");

        // W1C race with reset-asserted event
        step(1);
        reset_in = 1'b0;
        step(10);
        rd(2'd1, 8'h02, 1'b0, "reset_released_ev1");
        wr(2'd1, 8'h02);
        rd(2'd1, 8'h00, 1'b0, "ev1_cleared");
        step(1);
        reset_in = 1'b1;
        step(4);
        wr(2'd1, 8'h01);
        rd(2'd1, 8'h01, 1'b0, "w1c_race_set_wins");
        reset_in = 1'b0;
        step(10);
        wr(2'd1, 8'h0F);
        rd(2'd1, 8'h00, 1'b0, "ev_all_cleared");
        rd(2'd0, 8'h02, 1'b0, "status_idle");

        // glitch rejection
        step(1);
        batfl_in = 1'b0;
        step(3);
        batfl_in = 1'b1;
        step(10);
        rd(2'd0, 8'h02, 1'b0, "glitch_status");
        rd(2'd1, 8'h00, 1'b0, "glitch_event");
        rd(2'd3, 8'h00, 1'b0, "glitch_count");

        // long battery fail
        step(1);
        batfl_in = 1'b0;
        step(4);
        rd(2'd0, 8'h02, 1'b0, "batfl_k4_status");
        rd(2'd0, 8'h00, 1'b0, "batfl_k5_status");
        rd(2'd1, 8'h04, 1'b0, "batfl_event");
        rd(2'd3, 8'h01, 1'b0, "batfl_count1");
        step(3);
        batfl_in = 1'b1;
        step(10);
        rd(2'd1, 8'h0C, 1'b0, "batfl_recovered");
        wr(2'd1, 8'h0F);
        rd(2'd1, 8'h00, 1'b0, "ev_cleared2");

        // interrupt path
        wr(2'd2, 8'h04);
        rd(2'd2, 8'h04, 1'b0, "mask_readback");
        step(1);
        batfl_in = 1'b0;
        step(4);
        rd(2'd1, 8'h00, 1'b0, "irq_pre_event");
        rd(2'd1, 8'h04, 1'b0, "irq_event_edge");
        rd(2'd1, 8'h04, 1'b1, "irq_raised");
        wr(2'd1, 8'h01);
        rd(2'd1, 8'h04, 1'b1, "irq_held_other_clear");
        wr(2'd1, 8'h04);
        rd(2'd1, 8'h00, 1'b0, "irq_cleared");
        step(1);
        batfl_in = 1'b1;
        step(10);
        rd(2'd1, 8'h08, 1'b0, "recover_unmasked");
        wr(2'd1, 8'h08);

        // saturation: count is 2 here
        for (int n = 0; n < 300; n++) begin
            batfl_in = 1'b0;
            step(7);
            batfl_in = 1'b1;
            step(7);
        end
        rd(2'd3, 8'hFF, 1'b1, "count_saturated");
        wr(2'd3, 8'hAA);
        rd(2'd3, 8'h00, 1'b1, "count_cleared");
        wr(2'd2, 8'h00);
        rd(2'd2, 8'h00, 1'b0, "mask_cleared_irq_low");
        wr(2'd1, 8'h0F);
        rd(2'd1, 8'h00, 1'b0, "ev_cleared3");

        // count clear coinciding with increment
        step(1);
        batfl_in = 1'b0;
        step(4);
        wr(2'd3, 8'h00);
        rd(2'd3, 8'h01, 1'b0, "clear_inc_race");
        rd(2'd1, 8'h04, 1'b0, "race_event");
        step(1);
        batfl_in = 1'b1;
        step(10);
        wr(2'd1, 8'h0F);

        // async reset mid-debounce
        step(1);
        reset_in = 1'b1;
        step(3);
        #2 rst = 1'b1;
        rd(2'd0, 8'h02, 1'b0, "mid_rst_status");
        rd(2'd1, 8'h00, 1'b0, "mid_rst_event");
        rd(2'd2, 8'h00, 1'b0, "mid_rst_mask");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 1; i <= 5; i++) rd(2'd0, 8'h02, 1'b0, "mid_rst_refresh_pre");
        rd(2'd0, 8'h03, 1'b0, "mid_rst_refresh_rise");
        rd(2'd1, 8'h01, 1'b0, "mid_rst_refresh_event");
        rd(2'd3, 8'h00, 1'b0, "mid_rst_count");

        step(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending expectations expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
